// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA rectangle-fill arbiter.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W_DEF = 3;

    // Per-client slice widths inside the packed request buses.
    localparam int X_W = 8;
    localparam int Y_W = 7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               vld
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + 32'(i)) % NUM_REQ);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA pixel-write port between rectangle-fill clients; one pixel per clock.
// Outputs are registered; off-screen pixels are suppressed (plot=0) but still take a cycle.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*X_W-1:0]       req_w,
    input  logic [NUM_REQ*Y_W-1:0]       req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot
);

    localparam int         PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

    logic [X_W-1:0]      rx [NUM_REQ];
    logic [Y_W-1:0]      ry [NUM_REQ];
    logic [X_W-1:0]      rw [NUM_REQ];
    logic [Y_W-1:0]      rh [NUM_REQ];
    logic [COLOUR_W-1:0] rc [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rx[g] = req_x[g*X_W +: X_W];
        assign ry[g] = req_y[g*Y_W +: Y_W];
        assign rw[g] = req_w[g*X_W +: X_W];
        assign rh[g] = req_h[g*Y_W +: Y_W];
        assign rc[g] = req_colour[g*COLOUR_W +: COLOUR_W];
    end

    state_e              state_q,  state_d;
    logic [PTR_W-1:0]    ptr_q,    ptr_d;
    logic [PTR_W-1:0]    win_q,    win_d;
    logic [X_W-1:0]      x0_q,     x0_d;
    logic [Y_W-1:0]      y0_q,     y0_d;
    logic [X_W-1:0]      w_q,      w_d;
    logic [Y_W-1:0]      h_q,      h_d;
    logic [COLOUR_W-1:0] col_q,    col_d;
    logic [X_W-1:0]      cx_q,     cx_d;
    logic [Y_W-1:0]      cy_q,     cy_d;
    logic [X_W-1:0]      x_q,      x_d;
    logic [Y_W-1:0]      y_q,      y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q,   plot_d;
    logic [NUM_REQ-1:0]  grant_q,  grant_d;
    logic [NUM_REQ-1:0]  done_q,   done_d;
    logic                busy_q,   busy_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_vld;
    logic [PTR_W-1:0]    arb_idx;
    logic [8:0]          x_sum;
    logic [7:0]          y_sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .vld (arb_vld)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    win_d   = arb_idx;
                    x0_d    = rx[arb_idx];
                    y0_d    = ry[arb_idx];
                    w_d     = rw[arb_idx];
                    h_d     = rh[arb_idx];
                    col_d   = rc[arb_idx];
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (rw[arb_idx] == '0 || rh[arb_idx] == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (cx_q == w_q - X_W'(1)) begin
                    cx_d = '0;
                    if (cy_q == h_q - Y_W'(1)) state_d = ST_DONE;
                    else                       cy_d    = cy_q + Y_W'(1);
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + PTR_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they line up with the registered state.
    always_comb begin
        x_sum    = {1'b0, x0_d} + {1'b0, cx_d};
        y_sum    = {1'b0, y0_d} + {1'b0, cy_d};
        x_d      = '0;
        y_d      = '0;
        colour_d = '0;
        plot_d   = 1'b0;
        grant_d  = '0;
        done_d   = '0;
        busy_d   = (state_d != ST_IDLE);
        if (state_d == ST_FILL) begin
            x_d            = x_sum[X_W-1:0];
            y_d            = y_sum[Y_W-1:0];
            colour_d       = col_d;
            plot_d         = (x_sum < SCR_W9) && (y_sum < SCR_H8);
            grant_d[win_d] = 1'b1;
        end
        if (state_d == ST_DONE) done_d[win_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: request table plus contention and mid-fill reset sequences.
module tb_vga_draw_arbiter;

    localparam int N  = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*8-1:0]  req_x = '0;
    logic [N*7-1:0]  req_y = '0;
    logic [N*8-1:0]  req_w = '0;
    logic [N*7-1:0]  req_h = '0;
    logic [N*CW-1:0] req_colour = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [CW-1:0]   colour;
    logic            plot;

    vga_draw_arbiter #(
        .NUM_REQ  (N),
        .SCREEN_W (160),
        .SCREEN_H (120),
        .COLOUR_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic          busy;
        logic [7:0]    x;
        logic [6:0]    y;
        logic [CW-1:0] colour;
        logic          plot;
    } pix_t;

    typedef struct {
        int c;
        int x0, y0, w, h, col;
        int exp_plots, exp_fill, exp_lat;
    } vec_t;

    pix_t pix_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   plot_cnt = 0;
    int   fill_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every FILL cycle and every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (grant != '0 || plot) begin
                pix_t cur;
                pix_t exp;
                cur = '{grant: grant, busy: busy, x: x, y: y, colour: colour, plot: plot};
                fill_cnt++;
                if (plot) plot_cnt++;
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel actual=%0h required=none", cur);
                end else begin
                    exp = pix_q.pop_front();
                    check("pixel", 64'(cur), 64'(exp));
                end
            end
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%0h required=none", done);
                end else begin
                    check("done_vec", 64'(done), 64'(1) << done_q.pop_front());
                end
            end
        end
    end

    task automatic load_req(input int c, input int x0, input int y0, input int w, input int h, input int col);
        req_x[c*8 +: 8]       = 8'(x0);
        req_y[c*7 +: 7]       = 7'(y0);
        req_w[c*8 +: 8]       = 8'(w);
        req_h[c*7 +: 7]       = 7'(h);
        req_colour[c*CW +: CW] = CW'(col);
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                pix_t p;
                int   px;
                int   py;
                px       = x0 + i;
                py       = y0 + j;
                p.grant  = N'(1 << c);
                p.busy   = 1'b1;
                p.x      = 8'(px);
                p.y      = 7'(py);
                p.colour = CW'(col);
                p.plot   = (px < 160) && (py < 120);
                pix_q.push_back(p);
            end
        end
        done_q.push_back(c);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int lat;
        bit got;
        @(posedge clk);
        #1;
        plot_cnt = 0;
        fill_cnt = 0;
        load_req(v.c, v.x0, v.y0, v.w, v.h, v.col);
        req[v.c] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < v.exp_lat + 20) begin
            @(negedge clk);
            lat++;
            if (done[v.c]) got = 1'b1;
        end
        req[v.c] = 1'b0;
        check($sformatf("row%0d_latency", k), 64'(lat), 64'(v.exp_lat));
        check($sformatf("row%0d_plots", k), 64'(plot_cnt), 64'(v.exp_plots));
        check($sformatf("row%0d_fill_cycles", k), 64'(fill_cnt), 64'(v.exp_fill));
        check($sformatf("row%0d_queue_drained", k), 64'(pix_q.size()), 64'(0));
        @(negedge clk);
        check($sformatf("row%0d_idle_after", k), 64'({busy, plot, grant, done, x, y, colour}), 64'(0));
        pix_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        int seen;
        vec_t v;

        // client, x0, y0, w, h, colour, plotted pixels, FILL cycles, negedges from req to done
        vecs[0] = '{c: 0, x0: 10,  y0: 52,  w: 2,   h: 16,  col: 4, exp_plots: 32,    exp_fill: 32,    exp_lat: 34};
        vecs[1] = '{c: 2, x0: 20,  y0: 20,  w: 0,   h: 5,   col: 7, exp_plots: 0,     exp_fill: 0,     exp_lat: 2};
        vecs[2] = '{c: 1, x0: 158, y0: 118, w: 4,   h: 3,   col: 1, exp_plots: 4,     exp_fill: 12,    exp_lat: 14};
        vecs[3] = '{c: 0, x0: 250, y0: 125, w: 8,   h: 4,   col: 2, exp_plots: 0,     exp_fill: 32,    exp_lat: 34};
        vecs[4] = '{c: 3, x0: 0,   y0: 0,   w: 160, h: 120, col: 0, exp_plots: 19200, exp_fill: 19200, exp_lat: 19202};

        #12;
        check("reset_outputs", 64'({busy, plot, grant, done, x, y, colour}), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 64'({busy, plot, grant, done, x, y, colour}), 64'(0));

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // Contention: both held, expected service order 0,1,0,1.
        do_reset();
        @(posedge clk);
        #1;
        load_req(0, 30, 30, 2, 1, 3);
        load_req(1, 40, 40, 2, 1, 5);
        load_req(0, 30, 30, 2, 1, 3);
        load_req(1, 40, 40, 2, 1, 5);
        req  = 4'b0011;
        seen = 0;
        for (int n = 0; n < 100 && seen < 4; n++) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        req = '0;
        check("contention_done_count", 64'(seen), 64'(4));
        check("contention_queue_drained", 64'(pix_q.size()), 64'(0));
        @(negedge clk);
        pix_q.delete();
        done_q.delete();

        // Move the pointer to 2, then abort a client-2 fill on its 10th pixel.
        v = '{c: 1, x0: 1, y0: 1, w: 1, h: 1, col: 1, exp_plots: 1, exp_fill: 1, exp_lat: 3};
        run_vec(5, v);
        @(posedge clk);
        #1;
        load_req(2, 5, 5, 2, 16, 6);
        req[2] = 1'b1;
        seen   = 0;
        for (int n = 0; n < 40 && seen < 10; n++) begin
            @(negedge clk);
            if (grant != '0) seen++;
        end
        check("abort_pixels_before_reset", 64'(seen), 64'(10));
        #1;
        rst = 1'b0;
        #1;
        check("abort_outputs_async", 64'({busy, plot, grant, done}), 64'(0));
        req = '0;
        pix_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("no_done_after_abort", 64'({busy, done}), 64'(0));

        // Pointer back at 0 after reset: client 1 must win over client 3.
        @(posedge clk);
        #1;
        load_req(1, 60, 60, 1, 1, 2);
        load_req(3, 70, 70, 1, 1, 1);
        req  = 4'b1010;
        seen = 0;
        for (int n = 0; n < 40 && seen < 2; n++) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        req = '0;
        check("post_reset_done_count", 64'(seen), 64'(2));
        check("post_reset_queue_drained", 64'(pix_q.size()), 64'(0));
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
